smg_scan_decoder: RTL and testbench

SMG_SCAN_DECODER -- requirements
Module: smg_scan_decoder

---
 rtl/smg_scan_decoder.sv | 156 +++++++++++++++
 tb/tb_smg_scan_decoder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/smg_scan_decoder.sv
// smg_scan_decoder: recovers a two-digit BCD value from a multiplexed 7-segment scan (optional idle watchdog via SMG_TIMEOUT_EN)
module smg_scan_decoder #(
    parameter int STABLE_CNT     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] Row_Scan_Sig,
    input  logic [1:0] Column_Scan_Sig,
    output logic [3:0] Ten_Digit,
    output logic [3:0] One_Digit,
    output logic       Data_Valid,
    output logic       Decode_Err,
    output logic       Scan_Lost
);
    typedef enum logic [1:0] {HUNT, TEN, ONE} state_t;
    state_t      r_state, w_next;
    logic [1:0]  r_col_s1, r_col_s2, r_col_p;
    logic [7:0]  r_seg_s1, r_seg_s2;
    logic [6:0]  r_seg_p;
    logic [7:0]  r_cnt;
    logic        r_seen;
    logic [3:0]  r_shadow, r_ten, r_one;
    logic        r_dv, r_err;
    logic [1:0]  w_col;
    logic [6:0]  w_seg;
    logic        w_unused_dp;
    logic        w_same, w_chg, w_stable, w_bad_col, w_to;
    logic        w_ok;
    logic [3:0]  w_dig;
    logic        w_acc_ten, w_acc_one, w_dv, w_err, w_counting;

    assign w_col       = r_col_s2;
    assign w_seg       = r_seg_s2[6:0];
    assign w_unused_dp = r_seg_s2[7];
    assign w_same      = (w_col == r_col_p) && (w_seg == r_seg_p);
    assign w_chg       = w_col != r_col_p;
    assign w_stable    = r_cnt == 8'(STABLE_CNT);
    assign w_bad_col   = w_col == 2'b00;

    // segment pattern to BCD, DP ignored; unknown patterns flag !w_ok
    always_comb begin
        w_ok  = 1'b1;
        w_dig = 4'd0;
        case (w_seg)
            7'h40: w_dig = 4'd0;
            7'h79: w_dig = 4'd1;
            7'h24: w_dig = 4'd2;
            7'h30: w_dig = 4'd3;
            7'h19: w_dig = 4'd4;
            7'h12: w_dig = 4'd5;
            7'h02: w_dig = 4'd6;
            7'h78: w_dig = 4'd7;
            7'h00: w_dig = 4'd8;
            7'h10: w_dig = 4'd9;
            default: w_ok = 1'b0;
        endcase
    end

`ifdef SMG_TIMEOUT_EN
    logic [19:0] r_idle;
    logic        r_lost;
    assign w_to      = r_idle == 20'(TIMEOUT_CYCLES);
    assign Scan_Lost = r_lost;
    // idle watchdog: restarts on every column change, latches Scan_Lost when it saturates
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_idle <= '0;
            r_lost <= 1'b0;
        end else begin
            r_idle <= w_chg ? 20'd0 : (w_to ? r_idle : r_idle + 20'd1);
            r_lost <= w_chg ? 1'b0 : (w_to ? 1'b1 : r_lost);
        end
    end
`else
    assign w_to      = 1'b0;
    assign Scan_Lost = 1'b0;
`endif

    // two-flop input synchroniser plus the previous sample used for stability
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_col_s1 <= 2'b11;
            r_col_s2 <= 2'b11;
            r_col_p  <= 2'b11;
            r_seg_s1 <= 8'hFF;
            r_seg_s2 <= 8'hFF;
            r_seg_p  <= 7'h7F;
        end else begin
            r_col_s1 <= Column_Scan_Sig;
            r_col_s2 <= r_col_s1;
            r_col_p  <= w_col;
            r_seg_s1 <= Row_Scan_Sig;
            r_seg_s2 <= r_seg_s1;
            r_seg_p  <= w_seg;
        end
    end

    // state register
    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= HUNT;
        else
            r_state <= w_next;
    end

    // next state: illegal column or watchdog always wins, then per-state progress
    always_comb begin
        w_next = r_state;
        if (w_bad_col || w_to)
            w_next = HUNT;
        else
            case (r_state)
                HUNT:    w_next = (w_col == 2'b01) ? TEN : HUNT;
                TEN:     w_next = (w_col != 2'b01) ? HUNT : (w_acc_ten ? (w_ok ? ONE : HUNT) : TEN);
                ONE:     w_next = w_acc_one ? HUNT : ((w_col == 2'b01 && r_seen) ? TEN : ONE);
                default: w_next = HUNT;
            endcase
    end

    // outputs of the FSM: digit acceptance, frame-valid and error pulses
    always_comb begin
        w_acc_ten  = (r_state == TEN) && (w_col == 2'b01) && w_stable && !w_to;
        w_acc_one  = (r_state == ONE) && (w_col == 2'b10) && w_stable && !w_to;
        w_dv       = w_acc_one && w_ok;
        w_err      = (w_bad_col && w_chg) || ((w_acc_ten || w_acc_one) && !w_ok);
        w_counting = ((r_state == TEN) && (w_col == 2'b01)) || ((r_state == ONE) && (w_col == 2'b10));
    end

    // stability counter, one-column-seen flag, shadow and result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt    <= '0;
            r_seen   <= 1'b0;
            r_shadow <= '0;
            r_ten    <= '0;
            r_one    <= '0;
            r_dv     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_cnt    <= (w_next != r_state) ? 8'd0 :
                        (w_counting ? (w_same ? ((r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1) : 8'd1) : r_cnt);
            r_seen   <= (w_next != r_state) ? 1'b0 : (r_seen || (r_state == ONE && w_col == 2'b10));
            r_shadow <= (w_acc_ten && w_ok) ? w_dig : r_shadow;
            r_ten    <= w_dv ? r_shadow : r_ten;
            r_one    <= w_dv ? w_dig : r_one;
            r_dv     <= w_dv;
            r_err    <= w_err;
        end
    end

    assign Ten_Digit  = r_ten;
    assign One_Digit  = r_one;
    assign Data_Valid = r_dv;
    assign Decode_Err = r_err;
endmodule

// File: tb/tb_smg_scan_decoder.sv
// tb_smg_scan_decoder: directed self-checking bench for smg_scan_decoder
module tb_smg_scan_decoder;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] row = 8'hFF;
    logic [1:0] col = 2'b11;
    logic [3:0] ten, one;
    logic       dv, err, lost;
    int         n_chk = 0, n_err = 0;
    int         cyc = 0, dv_cnt = 0, err_cnt = 0, both_cnt = 0, dv_cyc = 0;
    int         d0, e0, t0;

    smg_scan_decoder #(.STABLE_CNT(4), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST), .Row_Scan_Sig(row), .Column_Scan_Sig(col),
        .Ten_Digit(ten), .One_Digit(one), .Data_Valid(dv), .Decode_Err(err), .Scan_Lost(lost)
    );

    always #5 CLK = ~CLK;

    // cycle counter for latency measurement
    always @(posedge CLK) cyc <= cyc + 1;

    // pulse monitor sampled on the falling edge
    always @(negedge CLK) begin
        if (!RST) begin
            dv_cnt  = dv_cnt + int'(dv);
            err_cnt = err_cnt + int'(err);
            if (dv && err) both_cnt = both_cnt + 1;
            if (dv) dv_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic [7:0] r, input int n);
        col = c;
        row = r;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic snap();
        d0 = dv_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ten", int'(ten), 0);
        chk("rst_one", int'(one), 0);
        chk("rst_dv", int'(dv), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_lost", int'(lost), 0);
        RST = 1'b0;

        snap();
        t0 = cyc;
        drive(2'b01, 8'hA4, 10);
        drive(2'b10, 8'hB0, 10);
        drive(2'b11, 8'hFF, 6);
        chk("t1_dv", dv_cnt - d0, 1);
        chk("t1_err", err_cnt - e0, 0);
        chk("t1_ten", int'(ten), 2);
        chk("t1_one", int'(one), 3);
        chk("t1_latency", int'((dv_cyc - t0) >= 10), 1);

        snap();
        drive(2'b01, 8'h92, 3);
        drive(2'b10, 8'hC0, 10);
        drive(2'b11, 8'hFF, 6);
        chk("t2_dv", dv_cnt - d0, 0);
        chk("t2_err", err_cnt - e0, 0);

        snap();
        drive(2'b01, 8'hF8, 10);
        drive(2'b10, 8'hFF, 10);
        drive(2'b11, 8'hFF, 6);
        chk("t3_err", err_cnt - e0, 1);
        chk("t3_dv", dv_cnt - d0, 0);
        chk("t3_ten", int'(ten), 2);
        chk("t3_one", int'(one), 3);

        snap();
        drive(2'b01, 8'hC0, 3);
        drive(2'b00, 8'hFF, 5);
        chk("t4_state", int'(dut.r_state), 0);
        drive(2'b11, 8'hFF, 6);
        chk("t4_err", err_cnt - e0, 1);
        chk("t4_dv", dv_cnt - d0, 0);

        snap();
        drive(2'b01, 8'h99, 10);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        drive(2'b10, 8'hF9, 10);
        drive(2'b11, 8'hFF, 6);
        chk("t5_dv", dv_cnt - d0, 0);
        chk("t5_ten", int'(ten), 0);
        chk("t5_one", int'(one), 0);

        snap();
        drive(2'b01, 8'hC0, 10);
        drive(2'b10, 8'hA4, 2);
        drive(2'b01, 8'hF9, 10);
        drive(2'b10, 8'h82, 10);
        drive(2'b11, 8'hFF, 6);
        chk("t6_dv", dv_cnt - d0, 1);
        chk("t6_err", err_cnt - e0, 0);
        chk("t6_ten", int'(ten), 1);
        chk("t6_one", int'(one), 6);

        chk("dv_err_overlap", both_cnt, 0);

        drive(2'b01, 8'hC0, 10);
        chk("t7_lost_early", int'(lost), 0);
        drive(2'b01, 8'hC0, 12);
`ifdef SMG_TIMEOUT_EN
        chk("t7_lost_set", int'(lost), 1);
        drive(2'b11, 8'hFF, 4);
        chk("t7_lost_clr", int'(lost), 0);
`else
        chk("t7_lost_tied", int'(lost), 0);
        drive(2'b11, 8'hFF, 4);
        chk("t7_lost_tied2", int'(lost), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
